// File: rtl/axi_rd_arbiter.sv
// rtl/axi_rd_arbiter.sv - two-master AXI4 read arbiter holding one grant per burst
// Optional macro ARB_FIXED_PRIO_EN: fixed priority, master 1 wins ties.
module axi_rd_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] m0_araddr,
    input  logic              m0_arvalid,
    input  logic [1:0]        m0_arburst,
    input  logic [7:0]        m0_arlen,
    input  logic [2:0]        m0_arsize,
    output logic              m0_arready,
    output logic [DATA_W-1:0] m0_rdata,
    output logic [1:0]        m0_rresp,
    output logic              m0_rvalid,
    output logic              m0_rlast,
    input  logic              m0_rready,
    input  logic [ADDR_W-1:0] m1_araddr,
    input  logic              m1_arvalid,
    input  logic [1:0]        m1_arburst,
    input  logic [7:0]        m1_arlen,
    input  logic [2:0]        m1_arsize,
    output logic              m1_arready,
    output logic [DATA_W-1:0] m1_rdata,
    output logic [1:0]        m1_rresp,
    output logic              m1_rvalid,
    output logic              m1_rlast,
    input  logic              m1_rready,
    output logic [ADDR_W-1:0] s_araddr,
    output logic              s_arvalid,
    output logic [1:0]        s_arburst,
    output logic [7:0]        s_arlen,
    output logic [2:0]        s_arsize,
    input  logic              s_arready,
    input  logic [DATA_W-1:0] s_rdata,
    input  logic [1:0]        s_rresp,
    input  logic              s_rvalid,
    input  logic              s_rlast,
    output logic              s_rready,
    output logic [1:0]        grant,
    output logic              burst_err
);

    typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

    state_t     state_q, state_d;
    logic [1:0] grant_q, grant_d;
    logic       burst_err_q, burst_err_d;
    logic [8:0] beat_cnt_q, beat_cnt_d;
    logic [7:0] arlen_q, arlen_d;
`ifndef ARB_FIXED_PRIO_EN
    logic       last_q, last_d;
`endif

    logic pick1;
    logic r_en0, r_en1;
    logic r_hs;

    always_comb begin
`ifdef ARB_FIXED_PRIO_EN
        pick1 = m1_arvalid;
`else
        // on a tie, the master that did not own the previous burst wins
        pick1 = m1_arvalid & (~m0_arvalid | ~last_q);
`endif
    end

    always_comb begin
        s_arvalid = 1'b0;
        s_araddr  = '0;
        s_arburst = '0;
        s_arlen   = '0;
        s_arsize  = '0;
        if (state_q == ADDR) begin
            s_arvalid = 1'b1;
            s_araddr  = grant_q[1] ? m1_araddr  : m0_araddr;
            s_arburst = grant_q[1] ? m1_arburst : m0_arburst;
            s_arlen   = grant_q[1] ? m1_arlen   : m0_arlen;
            s_arsize  = grant_q[1] ? m1_arsize  : m0_arsize;
        end
        m0_arready = (state_q == ADDR) & s_arready & grant_q[0];
        m1_arready = (state_q == ADDR) & s_arready & grant_q[1];

        r_en0 = (state_q == DATA) & grant_q[0];
        r_en1 = (state_q == DATA) & grant_q[1];
        s_rready  = (r_en0 & m0_rready) | (r_en1 & m1_rready);
        m0_rvalid = r_en0 & s_rvalid;
        m0_rlast  = r_en0 & s_rlast;
        m0_rdata  = r_en0 ? s_rdata : '0;
        m0_rresp  = r_en0 ? s_rresp : '0;
        m1_rvalid = r_en1 & s_rvalid;
        m1_rlast  = r_en1 & s_rlast;
        m1_rdata  = r_en1 ? s_rdata : '0;
        m1_rresp  = r_en1 ? s_rresp : '0;
        r_hs      = s_rvalid & s_rready;
    end

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        burst_err_d = burst_err_q;
        beat_cnt_d  = beat_cnt_q;
        arlen_d     = arlen_q;
`ifndef ARB_FIXED_PRIO_EN
        last_d      = last_q;
`endif
        case (state_q)
            IDLE: begin
                if (m0_arvalid | m1_arvalid) begin
                    grant_d    = pick1 ? 2'b10 : 2'b01;
                    beat_cnt_d = '0;
                    state_d    = ADDR;
                end
            end
            ADDR: begin
                if (s_arready) begin
                    arlen_d = s_arlen;
                    state_d = DATA;
                end
            end
            DATA: begin
                if (r_hs) begin
                    beat_cnt_d = beat_cnt_q + 9'd1;
                    if (s_rlast) begin
                        // count excludes the current beat, so a correct burst ends with count == arlen
                        if (beat_cnt_q != {1'b0, arlen_q}) begin
                            burst_err_d = 1'b1;
                        end
`ifndef ARB_FIXED_PRIO_EN
                        last_d  = grant_q[1];
`endif
                        grant_d = '0;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            grant_q     <= '0;
            burst_err_q <= 1'b0;
            beat_cnt_q  <= '0;
            arlen_q     <= '0;
`ifndef ARB_FIXED_PRIO_EN
            last_q      <= 1'b1;
`endif
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            burst_err_q <= burst_err_d;
            beat_cnt_q  <= beat_cnt_d;
            arlen_q     <= arlen_d;
`ifndef ARB_FIXED_PRIO_EN
            last_q      <= last_d;
`endif
        end
    end

    assign grant     = grant_q;
    assign burst_err = burst_err_q;

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// tb/tb_axi_rd_arbiter.sv - self-checking bench for axi_rd_arbiter
module tb_axi_rd_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] m0_araddr, m1_araddr, s_araddr;
    logic        m0_arvalid, m1_arvalid, m0_arready, m1_arready;
    logic [1:0]  m0_arburst, m1_arburst, s_arburst;
    logic [7:0]  m0_arlen, m1_arlen, s_arlen;
    logic [2:0]  m0_arsize, m1_arsize, s_arsize;
    logic [63:0] m0_rdata, m1_rdata, s_rdata;
    logic [1:0]  m0_rresp, m1_rresp, s_rresp;
    logic        m0_rvalid, m1_rvalid, m0_rlast, m1_rlast, m0_rready, m1_rready;
    logic        s_arvalid, s_arready, s_rvalid, s_rlast, s_rready;
    logic [1:0]  grant;
    logic        burst_err;

    int errors = 0;
    int checks = 0;

    axi_rd_arbiter #(.ADDR_W(32), .DATA_W(64)) dut (
        .clk(clk), .rst(rst),
        .m0_araddr(m0_araddr), .m0_arvalid(m0_arvalid), .m0_arburst(m0_arburst),
        .m0_arlen(m0_arlen), .m0_arsize(m0_arsize), .m0_arready(m0_arready),
        .m0_rdata(m0_rdata), .m0_rresp(m0_rresp), .m0_rvalid(m0_rvalid),
        .m0_rlast(m0_rlast), .m0_rready(m0_rready),
        .m1_araddr(m1_araddr), .m1_arvalid(m1_arvalid), .m1_arburst(m1_arburst),
        .m1_arlen(m1_arlen), .m1_arsize(m1_arsize), .m1_arready(m1_arready),
        .m1_rdata(m1_rdata), .m1_rresp(m1_rresp), .m1_rvalid(m1_rvalid),
        .m1_rlast(m1_rlast), .m1_rready(m1_rready),
        .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arburst(s_arburst),
        .s_arlen(s_arlen), .s_arsize(s_arsize), .s_arready(s_arready),
        .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid),
        .s_rlast(s_rlast), .s_rready(s_rready),
        .grant(grant), .burst_err(burst_err)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    typedef struct {
        logic [1:0] mask;
        int         len;
        int         nbeats;
        int         ar_dly;
        int         stall_at;
        bit         late;
        int         w_rr;
        int         w_fp;
        bit         err;
    } vec_t;

    vec_t tbl[8];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic check_route(input int w, input logic [63:0] d, input logic [1:0] rs, input bit lst);
        chk("s_rready", s_rready, 1);
        chk("rvalid_win", w ? m1_rvalid : m0_rvalid, 1);
        chk("rdata_win", w ? m1_rdata : m0_rdata, d);
        chk("rresp_win", w ? m1_rresp : m0_rresp, rs);
        chk("rlast_win", w ? m1_rlast : m0_rlast, lst);
        chk("rvalid_lose", w ? m0_rvalid : m1_rvalid, 0);
        chk("rlast_lose", w ? m0_rlast : m1_rlast, 0);
        chk("rdata_lose", w ? m0_rdata : m1_rdata, 0);
        chk("rresp_lose", w ? m0_rresp : m1_rresp, 0);
    endtask

    // one complete burst: request, AR handshake after ar_dly wait cycles, nbeats data beats
    task automatic do_burst(input int idx, input logic [1:0] mask, input int len, input int nbeats,
                            input int ar_dly, input int stall_at, input bit late, input int w,
                            input bit exp_err);
        logic [31:0] a0, a1;
        logic [63:0] d;
        a0 = 32'h8000_0040 + (32'(idx) << 8);
        a1 = 32'h9000_0000 + (32'(idx) << 8);
        m0_araddr = a0;  m1_araddr = a1;
        m0_arlen  = 8'(len); m1_arlen = 8'(len);
        m0_arvalid = mask[0];
        m1_arvalid = mask[1];
        #1 chk("idle_s_arvalid", s_arvalid, 0);
        cyc(); #1;
        chk("grant", grant, w ? 2 : 1);
        chk("s_arvalid", s_arvalid, 1);
        chk("s_araddr", s_araddr, w ? a1 : a0);
        chk("s_arlen", s_arlen, 8'(len));
        chk("s_arsize", s_arsize, w ? 2 : 3);
        chk("s_arburst", s_arburst, w ? 2 : 1);
        for (int i = 0; i < ar_dly; i++) begin
            cyc(); #1 chk("arready_wait", {m1_arready, m0_arready}, 0);
        end
        cyc(); s_arready = 1'b1;
        #1 chk("arready", {m1_arready, m0_arready}, w ? 2 : 1);
        cyc(); s_arready = 1'b0;
        m0_arvalid = late && (w == 1);
        m1_arvalid = late && (w == 0);
        for (int b = 0; b < nbeats; b++) begin
            d = {$urandom, $urandom};
            s_rvalid = 1'b1; s_rdata = d; s_rresp = 2'(b); s_rlast = (b == nbeats - 1);
            if (b == stall_at) begin
                if (w == 1) m1_rready = 1'b0; else m0_rready = 1'b0;
                for (int s = 0; s < 3; s++) begin
                    #1 chk("stall_s_rready", s_rready, 0);
                    chk("stall_rvalid", w ? m1_rvalid : m0_rvalid, 1);
                    cyc();
                end
                m0_rready = 1'b1; m1_rready = 1'b1;
            end
            #1 check_route(w, d, 2'(b), b == nbeats - 1);
            if (late) chk("late_arready", w ? m0_arready : m1_arready, 0);
            cyc();
        end
        s_rvalid = 1'b0; s_rlast = 1'b0;
        #1;
        chk("end_grant", grant, 0);
        chk("burst_err", burst_err, exp_err);
        chk("end_s_arvalid", s_arvalid, 0);
        chk("end_s_rready", s_rready, 0);
    endtask

    initial begin
        int   prev;
        bit   merr;
        int   mask, len, nb, dly, stall, w;

        //           mask   len nb dly stall late rr fp err
        tbl[0] = '{2'b11, 7, 8, 2, -1, 0, 0, 1, 0};
        tbl[1] = '{2'b11, 3, 4, 0, -1, 0, 1, 1, 0};
        tbl[2] = '{2'b11, 0, 1, 0, -1, 0, 0, 1, 0};
        tbl[3] = '{2'b01, 5, 6, 0,  2, 1, 0, 0, 0};
        tbl[4] = '{2'b10, 3, 4, 1, -1, 0, 1, 1, 0};
        tbl[5] = '{2'b10, 7, 9, 0, -1, 0, 1, 1, 1};
        tbl[6] = '{2'b11, 1, 2, 0, -1, 0, 0, 1, 1};
        tbl[7] = '{2'b01, 2, 3, 0, -1, 0, 0, 0, 1};

        rst = 1'b0;
        m0_araddr = 32'h1234_5678; m1_araddr = 32'h0;
        m0_arvalid = 1'b1; m1_arvalid = 1'b1;
        m0_arburst = 2'd1; m1_arburst = 2'd2;
        m0_arlen = 8'd3; m1_arlen = 8'd3;
        m0_arsize = 3'd3; m1_arsize = 3'd2;
        m0_rready = 1'b1; m1_rready = 1'b1;
        s_arready = 1'b1; s_rvalid = 1'b1; s_rlast = 1'b1;
        s_rdata = 64'hdead_beef_0000_0001; s_rresp = 2'd2;
        #1;
        chk("rst_grant", grant, 0);
        chk("rst_burst_err", burst_err, 0);
        chk("rst_s_arvalid", s_arvalid, 0);
        chk("rst_s_araddr", s_araddr, 0);
        chk("rst_arready", {m1_arready, m0_arready}, 0);
        chk("rst_rvalid", {m1_rvalid, m0_rvalid}, 0);
        chk("rst_rdata", m0_rdata, 0);
        chk("rst_s_rready", s_rready, 0);
        m0_arvalid = 1'b0; m1_arvalid = 1'b0;
        s_arready = 1'b0; s_rvalid = 1'b0; s_rlast = 1'b0;
        cyc(); cyc();
        rst = 1'b1;

        for (int i = 0; i < 8; i++) begin
`ifdef ARB_FIXED_PRIO_EN
            do_burst(i, tbl[i].mask, tbl[i].len, tbl[i].nbeats, tbl[i].ar_dly,
                     tbl[i].stall_at, tbl[i].late, tbl[i].w_fp, tbl[i].err);
`else
            do_burst(i, tbl[i].mask, tbl[i].len, tbl[i].nbeats, tbl[i].ar_dly,
                     tbl[i].stall_at, tbl[i].late, tbl[i].w_rr, tbl[i].err);
`endif
        end

        // asynchronous reset in the middle of a data phase
        cyc();
        m0_araddr = 32'h8000_1000; m0_arvalid = 1'b1;
        cyc(); s_arready = 1'b1;
        cyc(); s_arready = 1'b0; m0_arvalid = 1'b0;
        s_rvalid = 1'b1; s_rdata = 64'h0123_4567_89ab_cdef;
        #1 chk("pre_rst_rvalid", m0_rvalid, 1);
        cyc();
        #2 rst = 1'b0;
        #1;
        chk("mid_rst_grant", grant, 0);
        chk("mid_rst_s_rready", s_rready, 0);
        chk("mid_rst_rvalid", m0_rvalid, 0);
        chk("mid_rst_burst_err", burst_err, 0);
        chk("mid_rst_s_arvalid", s_arvalid, 0);
        cyc();
        rst = 1'b1; s_rvalid = 1'b0;
        do_burst(20, 2'b10, 4, 5, 1, -1, 0, 1, 0);

        // randomized bursts against a transaction-level arbitration model
        cyc();
        rst = 1'b0;
        cyc();
        rst = 1'b1;
        prev = 1;
        merr = 0;
        for (int t = 0; t < 30; t++) begin
            mask  = $urandom_range(1, 3);
            len   = $urandom_range(0, 15);
            nb    = len + 1;
            if ($urandom_range(0, 5) == 0) nb = (len > 0 && $urandom_range(0, 1) == 1) ? len : len + 2;
            dly   = $urandom_range(0, 3);
            stall = ($urandom_range(0, 3) == 0) ? $urandom_range(0, len) : -1;
`ifdef ARB_FIXED_PRIO_EN
            w = (mask >= 2) ? 1 : 0;
`else
            w = (mask == 3) ? 1 - prev : ((mask == 2) ? 1 : 0);
`endif
            merr = merr | (nb != len + 1);
            do_burst(100 + t, 2'(mask), len, nb, dly, stall, 0, w, merr);
            prev = w;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
